// File: rtl/apb_mem_slave_p_pkg.sv
// Shared definitions for the parametrised APB memory slave:
// FSM state type, wait-counter width and a constant clog2 helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam int WAIT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_mem_slave_p_if.sv
// APB bus bundle between a master/decoder and one PSELx memory target.
interface apb_mem_slave_p_if #(
  parameter int DW = 32,
  parameter int AW = 8
);

  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_slave_p_ram.sv
// Word-organised RAM with synchronous per-byte write enables and an
// asynchronous read port; contents are never reset.
module apb_byte_ram
  import apb_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 64,
  localparam int NB = DW / 8,
  localparam int RAM_AW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     strb,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB slave over a byte-strobed RAM with programmable wait states,
// registered PREADY/PRDATA and PSLVERR on out-of-range word indices.
module apb_mem_slave_p
  import apb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int DEPTH = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_mem_slave_p_if.slave bus
);

  localparam int NB = DW / 8;
  localparam int LSB = clog2(NB);
  localparam int IDX_W = AW - LSB;
  localparam int IDX_W1 = IDX_W + 1;
  localparam int RAM_AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
  localparam logic [IDX_W:0] DEPTH_LIM = IDX_W1'(DEPTH);

  apb_state_t state, state_d;

  logic [IDX_W-1:0]  idx_q;
  logic              pwrite_q;
  logic [DW-1:0]     pwdata_q;
  logic [NB-1:0]     pstrb_q;
  logic [WAIT_W-1:0] cnt, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DW-1:0]     prdata_q, prdata_d;

  logic [IDX_W-1:0]  idx;
  logic              wr_cur;
  logic              err;
  logic              done;
  logic              ram_we;
  logic [DW-1:0]     ram_rdata;

  // In SETUP the completion may fall on this very edge, so use live bus values.
  assign idx    = (state == SETUP) ? bus.PADDR[AW-1:LSB] : idx_q;
  assign wr_cur = (state == SETUP) ? bus.PWRITE : pwrite_q;
  assign err    = {1'b0, idx} >= DEPTH_LIM;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (state == SETUP) begin
      idx_q    <= bus.PADDR[AW-1:LSB];
      pwrite_q <= bus.PWRITE;
      pwdata_q <= bus.PWDATA;
      pstrb_q  <= bus.PSTRB;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (bus.PSEL && !bus.PENABLE) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (pready_q) begin
          state_d = (bus.PSEL && !bus.PENABLE) ? SETUP : IDLE;
        end else if (!bus.PSEL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs default to zero, so any cycle that is not a completion clears them.
  always_comb begin
    cnt_d     = cnt;
    done      = 1'b0;
    ram_we    = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state)
      SETUP: begin
        cnt_d = WAIT_INIT;
        done  = (WAIT_STATES == 0);
      end
      ACCESS: begin
        if (pready_q) begin
          cnt_d  = '0;
          ram_we = pwrite_q && !err && PRESETn;
        end else if (!bus.PSEL) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt - 1'b1;
          done  = (cnt == WAIT_W'(1));
        end
      end
      default: cnt_d = cnt;
    endcase
    if (done) begin
      pready_d  = 1'b1;
      pslverr_d = err;
      if (!wr_cur && !err) begin
        prdata_d = ram_rdata;
      end
    end
  end

  apb_byte_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (PCLK),
    .we    (ram_we),
    .strb  (pstrb_q),
    .addr  (RAM_AW'(idx)),
    .wdata (pwdata_q),
    .rdata (ram_rdata)
  );

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p: three instances (0, 2 and 3 wait
// states) share one stimulus bus; 'sel' routes PSEL and the observed outputs.
module tb_apb_mem_slave_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          sel;
  logic        pready, pslverr;
  logic [31:0] prdata;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  apb_mem_slave_p_if #(.DW(32), .AW(12)) bus0 ();
  apb_mem_slave_p_if #(.DW(32), .AW(12)) bus2 ();
  apb_mem_slave_p_if #(.DW(32), .AW(12)) bus3 ();

  assign bus0.PSEL = psel && (sel == 0);
  assign bus2.PSEL = psel && (sel == 2);
  assign bus3.PSEL = psel && (sel == 3);
  assign bus0.PENABLE = penable;
  assign bus2.PENABLE = penable;
  assign bus3.PENABLE = penable;
  assign bus0.PWRITE = pwrite;
  assign bus2.PWRITE = pwrite;
  assign bus3.PWRITE = pwrite;
  assign bus0.PADDR = paddr;
  assign bus2.PADDR = paddr;
  assign bus3.PADDR = paddr;
  assign bus0.PWDATA = pwdata;
  assign bus2.PWDATA = pwdata;
  assign bus3.PWDATA = pwdata;
  assign bus0.PSTRB = pstrb;
  assign bus2.PSTRB = pstrb;
  assign bus3.PSTRB = pstrb;

  apb_mem_slave_p #(.DW(32), .AW(12), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .bus(bus0.slave));
  apb_mem_slave_p #(.DW(32), .AW(12), .DEPTH(64), .WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESETn(rst_n), .bus(bus2.slave));
  apb_mem_slave_p #(.DW(32), .AW(12), .DEPTH(64), .WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESETn(rst_n), .bus(bus3.slave));

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    case (sel)
      0: begin pready = bus0.PREADY; pslverr = bus0.PSLVERR; prdata = bus0.PRDATA; end
      2: begin pready = bus2.PREADY; pslverr = bus2.PSLVERR; prdata = bus2.PRDATA; end
      3: begin pready = bus3.PREADY; pslverr = bus3.PSLVERR; prdata = bus3.PRDATA; end
      default: ;
    endcase
  end

  // Drives the APB setup phase; the slave FSM enters SETUP on the next edge.
  task automatic setup_phase(input logic wr, input logic [11:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
  endtask

  task automatic access_phase(output logic [31:0] rdata, output logic err,
                              output int lat, output bit early_bad);
    penable = 1'b1; lat = -1; early_bad = 1'b0; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        lat = i; rdata = prdata; err = pslverr;
        break;
      end
      if (prdata !== 32'h0 || pslverr !== 1'b0) early_bad = 1'b1;
    end
  endtask

  task automatic go_idle();
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int lat, output bit early_bad, output logic rdy_after);
    setup_phase(wr, addr, data, strb);
    access_phase(rdata, err, lat, early_bad);
    go_idle();
    rdy_after = pready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
    repeat (2) @(negedge clk);
    checks++; if (pready !== 1'b0) begin fails++; $display("[TB] FAIL reset_pready: got %b expected 0", pready); end
    checks++; if (pslverr !== 1'b0) begin fails++; $display("[TB] FAIL reset_pslverr: got %b expected 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_prdata: got %h expected 0", prdata); end
    sel = 3;
    #1;
    checks++; if (pready !== 1'b0) begin fails++; $display("[TB] FAIL reset_pready_ws3: got %b expected 0", pready); end
    rst_n = 1'b1; sel = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat; bit eb; logic ra;
    sel = 0;
    xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL basic_wr_latency: got %0d expected 1", lat); end
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL basic_wr_pslverr: got %b expected 0", er); end
    xfer(1'b0, 12'h004, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL basic_rd_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL basic_rd_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL basic_rd_pslverr: got %b expected 0", er); end
    checks++; if (ra !== 1'b0) begin fails++; $display("[TB] FAIL basic_pready_one_cycle: got %b expected 0", ra); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat; bit eb; logic ra;
    sel = 3;
    xfer(1'b1, 12'h004, 32'h12345678, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL ws3_wr_latency: got %0d expected 4", lat); end
    xfer(1'b0, 12'h004, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL ws3_rd_latency: got %0d expected 4", lat); end
    checks++; if (eb !== 1'b0) begin fails++; $display("[TB] FAIL ws3_outputs_before_ready: got %b expected 0", eb); end
    checks++; if (rd !== 32'h12345678) begin fails++; $display("[TB] FAIL ws3_rd_data: got %h expected 12345678", rd); end
    checks++; if (ra !== 1'b0) begin fails++; $display("[TB] FAIL ws3_pready_one_cycle: got %b expected 0", ra); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int lat; bit eb; logic ra;
    sel = 0;
    xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, rd, er, lat, eb, ra);
    xfer(1'b1, 12'h008, 32'h11223344, 4'b0101, rd, er, lat, eb, ra);
    xfer(1'b0, 12'h008, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (rd !== 32'hFF22FF44) begin fails++; $display("[TB] FAIL strobe_merge: got %h expected ff22ff44", rd); end
    xfer(1'b1, 12'h008, 32'h00000000, 4'h0, rd, er, lat, eb, ra);
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL strobe_zero_pslverr: got %b expected 0", er); end
    xfer(1'b0, 12'h00B, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (rd !== 32'hFF22FF44) begin fails++; $display("[TB] FAIL strobe_zero_unaligned_rd: got %h expected ff22ff44", rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat; bit eb; logic ra;
    sel = 0;
    xfer(1'b1, 12'h000, 32'h55667788, 4'hF, rd, er, lat, eb, ra);
    xfer(1'b1, 12'h100, 32'hAAAAAAAA, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL range_wr_latency: got %0d expected 1", lat); end
    checks++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL range_wr_pslverr: got %b expected 1", er); end
    xfer(1'b0, 12'h100, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL range_rd_pslverr: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL range_rd_data: got %h expected 0", rd); end
    xfer(1'b0, 12'h000, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (rd !== 32'h55667788) begin fails++; $display("[TB] FAIL range_index0_intact: got %h expected 55667788", rd); end
    xfer(1'b1, 12'h0FC, 32'h76543210, 4'hF, rd, er, lat, eb, ra);
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL range_last_wr_pslverr: got %b expected 0", er); end
    xfer(1'b0, 12'h0FC, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (rd !== 32'h76543210) begin fails++; $display("[TB] FAIL range_last_rd_data: got %h expected 76543210", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit eb;
    sel = 0;
    setup_phase(1'b1, 12'h010, 32'hA5A5A5A5, 4'hF);
    access_phase(rd, er, lat, eb);
    setup_phase(1'b0, 12'h010, 32'h0, 4'hF);
    access_phase(rd, er, lat, eb);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL b2b_rd1_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL b2b_rd1_data: got %h expected a5a5a5a5", rd); end
    setup_phase(1'b1, 12'h014, 32'h01020304, 4'hF);
    access_phase(rd, er, lat, eb);
    checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL b2b_wr2_latency: got %0d expected 1", lat); end
    setup_phase(1'b0, 12'h014, 32'h0, 4'hF);
    access_phase(rd, er, lat, eb);
    checks++; if (rd !== 32'h01020304) begin fails++; $display("[TB] FAIL b2b_rd2_data: got %h expected 01020304", rd); end
    go_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat; bit eb; logic ra; bit seen;
    sel = 2;
    xfer(1'b1, 12'h020, 32'h0BADF00D, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 3) begin fails++; $display("[TB] FAIL ws2_wr_latency: got %0d expected 3", lat); end
    setup_phase(1'b1, 12'h020, 32'hFFFFFFFF, 4'hF);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL abort_outputs: got %b expected 0", seen); end
    xfer(1'b0, 12'h020, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (rd !== 32'h0BADF00D) begin fails++; $display("[TB] FAIL abort_no_write: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit eb; logic ra; bit seen;
    sel = 0;
    xfer(1'b1, 12'h030, 32'h11111111, 4'hF, rd, er, lat, eb, ra);
    setup_phase(1'b1, 12'h030, 32'h22222222, 4'hF);
    access_phase(rd, er, lat, eb);
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (pready !== 1'b0) begin fails++; $display("[TB] FAIL rst_wr_pready: got %b expected 0", pready); end
    xfer(1'b0, 12'h030, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (rd !== 32'h11111111) begin fails++; $display("[TB] FAIL rst_no_write: got %h expected 11111111", rd); end
    setup_phase(1'b0, 12'h030, 32'h0, 4'hF);
    access_phase(rd, er, lat, eb);
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (prdata !== 32'h0) begin fails++; $display("[TB] FAIL rst_rd_prdata: got %h expected 0", prdata); end
    checks++; if (pslverr !== 1'b0) begin fails++; $display("[TB] FAIL rst_rd_pslverr: got %b expected 0", pslverr); end
    sel = 3;
    setup_phase(1'b0, 12'h004, 32'h0, 4'hF);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL rst_ws3_idle_ignores_penable: got %b expected 0", seen); end
    go_idle();
    xfer(1'b0, 12'h004, 32'h0, 4'hF, rd, er, lat, eb, ra);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL rst_ws3_recover_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 32'h12345678) begin fails++; $display("[TB] FAIL rst_ws3_recover_data: got %h expected 12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_strobes();
    test_range();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
